// File: rtl/alu_op_decoder_pkg.sv
// Shared definitions for the ALU operand decoder: one-hot ALU opcodes, MIPS
// opcode/funct encodings, the decoded bundle and the skid-buffer state.
package alu_op_decoder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 16;

  // One-hot opcodes, bit-identical to the encoding the ALU consumes.
  localparam logic [OP_WIDTH-1:0] ALUOP_AND  = 16'h0001;
  localparam logic [OP_WIDTH-1:0] ALUOP_OR   = 16'h0002;
  localparam logic [OP_WIDTH-1:0] ALUOP_ADD  = 16'h0004;
  localparam logic [OP_WIDTH-1:0] ALUOP_SUB  = 16'h0008;
  localparam logic [OP_WIDTH-1:0] ALUOP_SLT  = 16'h0010;
  localparam logic [OP_WIDTH-1:0] ALUOP_XOR  = 16'h0020;
  localparam logic [OP_WIDTH-1:0] ALUOP_NOR  = 16'h0040;
  localparam logic [OP_WIDTH-1:0] ALUOP_SLTU = 16'h0080;
  localparam logic [OP_WIDTH-1:0] ALUOP_SLL  = 16'h0100;
  localparam logic [OP_WIDTH-1:0] ALUOP_SRL  = 16'h0200;
  localparam logic [OP_WIDTH-1:0] ALUOP_SRA  = 16'h0400;
  localparam logic [OP_WIDTH-1:0] ALUOP_LUI  = 16'h0800;
  localparam logic [OP_WIDTH-1:0] ALUOP_A    = 16'h1000;
  localparam logic [OP_WIDTH-1:0] ALUOP_B    = 16'h2000;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic                  trap_en;
    logic                  illegal;
  } alu_bundle_t;

  // EMPTY: nothing held; MAIN: main slot valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_MAIN  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_op_decoder_if.sv
// Instruction-in / decoded-bundle-out channel pair of the ALU operand decoder.
interface alu_op_decoder_if
  import alu_op_decoder_pkg::*;
  ();

  // Both channels use valid/ready: a beat transfers on a rising clk edge where
  // valid&ready; once valid is high the sender holds valid and payload stable
  // until the transfer, and ready never depends combinationally on valid.
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] inst;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  trap_en;
  logic                  illegal;

  modport slave (
    input  in_valid, inst, rs_data, rt_data, out_ready,
    output in_ready, out_valid, alu_op, alu_a, alu_b, trap_en, illegal
  );

  modport master (
    output in_valid, inst, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, alu_op, alu_a, alu_b, trap_en, illegal
  );

endinterface

// File: rtl/alu_op_decoder_decode.sv
// Combinational MIPS instruction decode into a one-hot ALU opcode plus the
// selected A/B operands; undecodable words yield an all-zero bundle with illegal set.
module mips_alu_decode
  import alu_op_decoder_pkg::*;
  (
    input  logic [DATA_WIDTH-1:0] inst,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output alu_bundle_t           bundle
  );

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;
  logic [DATA_WIDTH-1:0] shamt_zext;
  logic                  unused_reg_fields;

  assign opcode     = inst[31:26];
  assign funct      = inst[5:0];
  assign imm_sext   = {{(DATA_WIDTH-16){inst[15]}}, inst[15:0]};
  assign imm_zext   = {{(DATA_WIDTH-16){1'b0}}, inst[15:0]};
  assign shamt_zext = {{(DATA_WIDTH-5){1'b0}}, inst[10:6]};

  // Register indices were already used by the register file read.
  assign unused_reg_fields = ^inst[25:16];

  always_comb begin
    bundle = '0;
    case (opcode)
      OPC_RTYPE: begin
        bundle.alu_a = rs_data;
        bundle.alu_b = rt_data;
        case (funct)
          FUNCT_ADD:  begin bundle.alu_op = ALUOP_ADD; bundle.trap_en = 1'b1; end
          FUNCT_ADDU: bundle.alu_op = ALUOP_ADD;
          FUNCT_SUB:  begin bundle.alu_op = ALUOP_SUB; bundle.trap_en = 1'b1; end
          FUNCT_SUBU: bundle.alu_op = ALUOP_SUB;
          FUNCT_AND:  bundle.alu_op = ALUOP_AND;
          FUNCT_OR:   bundle.alu_op = ALUOP_OR;
          FUNCT_XOR:  bundle.alu_op = ALUOP_XOR;
          FUNCT_NOR:  bundle.alu_op = ALUOP_NOR;
          FUNCT_SLT:  bundle.alu_op = ALUOP_SLT;
          FUNCT_SLTU: bundle.alu_op = ALUOP_SLTU;
          // The ALU shifts B by A[4:0]; immediate shifts put shamt on A.
          FUNCT_SLL:  begin bundle.alu_op = ALUOP_SLL; bundle.alu_a = shamt_zext; end
          FUNCT_SRL:  begin bundle.alu_op = ALUOP_SRL; bundle.alu_a = shamt_zext; end
          FUNCT_SRA:  begin bundle.alu_op = ALUOP_SRA; bundle.alu_a = shamt_zext; end
          FUNCT_SLLV: bundle.alu_op = ALUOP_SLL;
          FUNCT_SRLV: bundle.alu_op = ALUOP_SRL;
          FUNCT_SRAV: bundle.alu_op = ALUOP_SRA;
          default: begin
            bundle         = '0;
            bundle.illegal = 1'b1;
          end
        endcase
      end
      OPC_ADDI: begin
        bundle.alu_op  = ALUOP_ADD;
        bundle.alu_a   = rs_data;
        bundle.alu_b   = imm_sext;
        bundle.trap_en = 1'b1;
      end
      OPC_ADDIU, OPC_LW, OPC_SW: begin
        bundle.alu_op = ALUOP_ADD;
        bundle.alu_a  = rs_data;
        bundle.alu_b  = imm_sext;
      end
      OPC_SLTI: begin
        bundle.alu_op = ALUOP_SLT;
        bundle.alu_a  = rs_data;
        bundle.alu_b  = imm_sext;
      end
      OPC_SLTIU: begin
        bundle.alu_op = ALUOP_SLTU;
        bundle.alu_a  = rs_data;
        bundle.alu_b  = imm_sext;
      end
      OPC_ANDI: begin
        bundle.alu_op = ALUOP_AND;
        bundle.alu_a  = rs_data;
        bundle.alu_b  = imm_zext;
      end
      OPC_ORI: begin
        bundle.alu_op = ALUOP_OR;
        bundle.alu_a  = rs_data;
        bundle.alu_b  = imm_zext;
      end
      OPC_XORI: begin
        bundle.alu_op = ALUOP_XOR;
        bundle.alu_a  = rs_data;
        bundle.alu_b  = imm_zext;
      end
      OPC_LUI: begin
        bundle.alu_op = ALUOP_LUI;
        bundle.alu_a  = rs_data;
        bundle.alu_b  = imm_zext;
      end
      default: bundle.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode/issue stage: decodes one instruction per handshake and registers the
// result behind a two-slot skid buffer so the ALU stage can stall losslessly.
module alu_op_decoder
  import alu_op_decoder_pkg::*;
  #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 16
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_decoder_if.slave  bus,
    output buf_state_e       dbg_state
  );

  if (DATA_WIDTH != alu_op_decoder_pkg::DATA_WIDTH ||
      OP_WIDTH != alu_op_decoder_pkg::OP_WIDTH) begin : g_bad_width
    $error("alu_op_decoder supports only DATA_WIDTH=32, OP_WIDTH=16");
  end

  alu_bundle_t dec_bundle;
  alu_bundle_t main_q, main_d;
  alu_bundle_t skid_q, skid_d;
  buf_state_e  state_q, state_d;
  logic        accept;
  logic        emit;

  mips_alu_decode u_decode (
    .inst    (bus.inst),
    .rs_data (bus.rs_data),
    .rt_data (bus.rt_data),
    .bundle  (dec_bundle)
  );

  // in_ready comes only from registered state, so out_ready never reaches it.
  assign bus.in_ready  = (state_q != BUF_FULL);
  assign bus.out_valid = (state_q != BUF_EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign emit          = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          main_d  = dec_bundle;
          state_d = BUF_MAIN;
        end
      end
      BUF_MAIN: begin
        case ({accept, emit})
          2'b11: main_d = dec_bundle;
          2'b10: begin
            skid_d  = dec_bundle;
            state_d = BUF_FULL;
          end
          2'b01: begin
            main_d  = '0;
            state_d = BUF_EMPTY;
          end
          default: ;
        endcase
      end
      BUF_FULL: begin
        // No accept is possible here, so the skid entry simply advances.
        if (emit) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = BUF_MAIN;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.alu_op  = main_q.alu_op;
  assign bus.alu_a   = main_q.alu_a;
  assign bus.alu_b   = main_q.alu_b;
  assign bus.trap_en = main_q.trap_en;
  assign bus.illegal = main_q.illegal;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed-vector bench for alu_op_decoder with a queue-based scoreboard.
module tb_alu_op_decoder;
  import alu_op_decoder_pkg::*;

  localparam int W = $bits(alu_bundle_t);

  logic       clk;
  logic       rst_n;
  buf_state_e dbg_state;
  int         n_total;
  int         n_bad;
  int         cyc;
  logic [W-1:0] exp_q[$];

  logic [31:0] v_inst[$];
  logic [31:0] v_rs[$];
  logic [31:0] v_rt[$];
  alu_bundle_t v_exp[$];

  alu_op_decoder_if bus ();

  alu_op_decoder #(.DATA_WIDTH(32), .OP_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic alu_bundle_t mk(input logic [15:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic trap,
                                     input logic ill);
    alu_bundle_t r;
    r.alu_op  = op;
    r.alu_a   = a;
    r.alu_b   = b;
    r.trap_en = trap;
    r.illegal = ill;
    return r;
  endfunction

  function automatic alu_bundle_t cur_out();
    return mk(bus.alu_op, bus.alu_a, bus.alu_b, bus.trap_en, bus.illegal);
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] i, input logic [31:0] rs,
                         input logic [31:0] rt, input alu_bundle_t e);
    v_inst.push_back(i);
    v_rs.push_back(rs);
    v_rt.push_back(rt);
    v_exp.push_back(e);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input int idx);
    bit accepted;
    accepted     = 1'b0;
    bus.inst     = v_inst[idx];
    bus.rs_data  = v_rs[idx];
    bus.rt_data  = v_rt[idx];
    bus.in_valid = 1'b1;
    for (int g = 0; g < 50 && !accepted; g++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(v_exp[idx]);
        accepted = 1'b1;
      end
      @(posedge clk);
      #2;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      n_total++;
      n_bad++;
      $display("FAIL send_timeout vec=%0d got=not_accepted exp=accepted", idx);
    end
  endtask

  task automatic drain(input string name);
    for (int g = 0; g < 60 && exp_q.size() != 0; g++) begin
      @(posedge clk);
      #2;
    end
    check32(name, exp_q.size(), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_output got=%h exp=none", cur_out());
      end else if (bus.out_ready) begin
        check("bundle", cur_out(), exp_q.pop_front());
      end else begin
        check("stall_hold", cur_out(), exp_q[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;

    add_vec(32'h00851020, 32'd7,        32'd9,        mk(ALUOP_ADD,  32'd7, 32'd9, 1'b1, 1'b0));
    add_vec(32'h2485FFFF, 32'd5,        32'h0000AAAA, mk(ALUOP_ADD,  32'd5, 32'hFFFFFFFF, 1'b0, 1'b0));
    add_vec(32'h3085FFFF, 32'h12345678, 32'h0,        mk(ALUOP_AND,  32'h12345678, 32'h0000FFFF, 1'b0, 1'b0));
    add_vec(32'h000510C0, 32'hFFFFFFFF, 32'h80000001, mk(ALUOP_SLL,  32'd3, 32'h80000001, 1'b0, 1'b0));
    add_vec(32'h3C051234, 32'h11,       32'h22,       mk(ALUOP_LUI,  32'h11, 32'h00001234, 1'b0, 1'b0));
    add_vec(32'h00851022, 32'd20,       32'd3,        mk(ALUOP_SUB,  32'd20, 32'd3, 1'b1, 1'b0));
    add_vec(32'h00851023, 32'd20,       32'd3,        mk(ALUOP_SUB,  32'd20, 32'd3, 1'b0, 1'b0));
    add_vec(32'h00851021, 32'd1,        32'd2,        mk(ALUOP_ADD,  32'd1, 32'd2, 1'b0, 1'b0));
    add_vec(32'h00851024, 32'hF0F0F0F0, 32'h0FF00FF0, mk(ALUOP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0));
    add_vec(32'h00851025, 32'hF0F0F0F0, 32'h0FF00FF0, mk(ALUOP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0));
    add_vec(32'h00851026, 32'hF0F0F0F0, 32'h0FF00FF0, mk(ALUOP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0));
    add_vec(32'h00851027, 32'hF0F0F0F0, 32'h0FF00FF0, mk(ALUOP_NOR,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0));
    add_vec(32'h0085102A, 32'hF0F0F0F0, 32'h0FF00FF0, mk(ALUOP_SLT,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0));
    add_vec(32'h0085102B, 32'hF0F0F0F0, 32'h0FF00FF0, mk(ALUOP_SLTU, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0));
    add_vec(32'h000517C2, 32'h5,        32'hF0000000, mk(ALUOP_SRL,  32'd31, 32'hF0000000, 1'b0, 1'b0));
    add_vec(32'h000510C3, 32'h5,        32'hF0000000, mk(ALUOP_SRA,  32'd3, 32'hF0000000, 1'b0, 1'b0));
    add_vec(32'h00851004, 32'h25,       32'd1,        mk(ALUOP_SLL,  32'h25, 32'd1, 1'b0, 1'b0));
    add_vec(32'h00851006, 32'h25,       32'd1,        mk(ALUOP_SRL,  32'h25, 32'd1, 1'b0, 1'b0));
    add_vec(32'h00851007, 32'h25,       32'hF0000000, mk(ALUOP_SRA,  32'h25, 32'hF0000000, 1'b0, 1'b0));
    add_vec(32'h20858000, 32'd1,        32'd2,        mk(ALUOP_ADD,  32'd1, 32'hFFFF8000, 1'b1, 1'b0));
    add_vec(32'h28858000, 32'd1,        32'd2,        mk(ALUOP_SLT,  32'd1, 32'hFFFF8000, 1'b0, 1'b0));
    add_vec(32'h2C857FFF, 32'd1,        32'd2,        mk(ALUOP_SLTU, 32'd1, 32'h00007FFF, 1'b0, 1'b0));
    add_vec(32'h34850F0F, 32'd1,        32'd2,        mk(ALUOP_OR,   32'd1, 32'h00000F0F, 1'b0, 1'b0));
    add_vec(32'h38858001, 32'd1,        32'd2,        mk(ALUOP_XOR,  32'd1, 32'h00008001, 1'b0, 1'b0));
    add_vec(32'h8C85FFFC, 32'h1000,     32'd2,        mk(ALUOP_ADD,  32'h1000, 32'hFFFFFFFC, 1'b0, 1'b0));
    add_vec(32'hAC850010, 32'h1000,     32'd2,        mk(ALUOP_ADD,  32'h1000, 32'h00000010, 1'b0, 1'b0));
    add_vec(32'hFC000000, 32'h55,       32'h66,       mk(16'h0, 32'h0, 32'h0, 1'b0, 1'b1));
    add_vec(32'h0000003F, 32'h55,       32'h66,       mk(16'h0, 32'h0, 32'h0, 1'b0, 1'b1));
    add_vec(32'h00000001, 32'h55,       32'h66,       mk(16'h0, 32'h0, 32'h0, 1'b0, 1'b1));
    add_vec(32'h04000000, 32'h55,       32'h66,       mk(16'h0, 32'h0, 32'h0, 1'b0, 1'b1));

    bus.in_valid  = 1'b0;
    bus.inst      = '0;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    #1;
    check("rst_bundle", cur_out(), '0);
    check32("rst_out_valid", 32'(bus.out_valid), 32'd0);
    #22 rst_n = 1'b1;
    @(posedge clk);
    #2;
    check32("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Full throughput: every vector back to back with out_ready held high.
    c0 = cyc;
    for (int i = 0; i < v_inst.size(); i++) send(i);
    check32("throughput_cycles", 32'(cyc - c0), 32'(v_inst.size()));
    drain("drain_directed");

    // Backpressure: two accepted, then in_ready drops, third waits.
    bus.out_ready = 1'b0;
    send(0);
    send(1);
    check32("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check32("bp_state_full", 32'(dbg_state), 32'(BUF_FULL));
    fork
      send(2);
      begin
        repeat (3) @(posedge clk);
        #2;
        check32("bp_still_blocked", 32'(bus.in_ready), 32'd0);
        check32("bp_queue_depth", exp_q.size(), 32'd2);
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Illegal words still complete the handshake in both slots.
    bus.out_ready = 1'b0;
    send(26);
    send(27);
    bus.out_ready = 1'b1;
    drain("drain_illegal");

    // Reset between edges with both slots full.
    bus.out_ready = 1'b0;
    send(3);
    send(4);
    check32("pre_rst_state_full", 32'(dbg_state), 32'(BUF_FULL));
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check32("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_bundle", cur_out(), '0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #2;
    check32("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    check32("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check32("postrst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #2;
    send(5);
    drain("drain_post_reset");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Decode/issue stage that produces the operands for the shared 32-bit ALU. Accepts one MIPS instruction word per handshake together with the two register-file read values. Emits the one-hot 16-bit ALU opcode and the selected A/B operands. Registers the result behind a 2-entry skid buffer so the ALU stage can stall without dropping or duplicating work.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width; only 32 is supported.
- OP_WIDTH, 16, one-hot ALU opcode width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  instruction/operand bundle valid.
- in_ready  out  1  decoder can accept; transfer when in_valid&in_ready.
- inst  in  32  MIPS instruction word.
- rs_data  in  32  value of register inst[25:21].
- rt_data  in  32  value of register inst[20:16].
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  ALU stage accepts; transfer when out_valid&out_ready.
- alu_op  out  16  one-hot ALU opcode (all-zero when illegal).
- alu_a  out  32  ALU A operand.
- alu_b  out  32  ALU B operand.
- trap_en  out  1  signed-overflow trap enabled (add, addi, sub).
- illegal  out  1  opcode/funct not decodable.

## Operation
- Opcode encodings (one-hot): AND=0x0001, OR=0x0002, ADD=0x0004, SUB=0x0008, SLT=0x0010, XOR=0x0020, NOR=0x0040, SLTU=0x0080, SLL=0x0100, SRL=0x0200, SRA=0x0400, LUI=0x0800, A=0x1000, B=0x2000.
- R-type (opcode 0x00), decoded by funct:
  - 0x20/0x21 map to ADD and 0x22/0x23 map to SUB; trap_en=1 for 0x20 and 0x22 only.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - For all of the above: A=rs_data, B=rt_data.
- Shifts: the ALU shifts B by A[4:0], so B=rt_data for every shift.
  - 0x00/0x02/0x03 map to SLL/SRL/SRA with A=zero-extended shamt (inst[10:6]).
  - 0x04/0x06/0x07 map to SLL/SRL/SRA with A=rs_data.
- I-type: A=rs_data in every case.
  - 0x08 ADD (trap), 0x09 ADD, 0x0A SLT, 0x0B SLTU: B=sign-extended imm.
  - 0x0C AND, 0x0D OR, 0x0E XOR: B=zero-extended imm.
  - 0x0F LUI: B=zero-extended imm.
  - 0x23 lw, 0x2B sw: ADD with sign-extended imm, trap_en=0.
- Any other opcode/funct: illegal=1, alu_op=0, A=B=0, trap_en=0. The bundle still flows through the buffer.
- Skid buffer: main slot drives the outputs; skid slot catches the bundle accepted in the cycle out_ready falls. Output order is strictly FIFO.

## Timing
- Latency: a bundle accepted at edge N is visible with out_valid=1 after edge N (registered, 1 cycle).
- in_ready = !skid_full, derived only from registered state; no combinational path from out_ready.
- Full throughput: with out_ready=1 held, one bundle per cycle.
- Main slot full and out_ready=0 when a bundle is accepted: the bundle goes to the skid slot and in_ready drops the next cycle.
- Simultaneous accept and emit with skid full: the skid slot moves to main, the new bundle is not accepted (in_ready=0), no loss.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset (including mid-operation): asynchronously clears both slots.
  - out_valid=0, alu_op=0, alu_a=0, alu_b=0, trap_en=0, illegal=0.
  - in_ready=1 from the first edge after release.
  - Buffered bundles are discarded.

## Structure
- The shared definitions package holds:
  - ALUOP_* one-hot constants (identical to those the ALU consumes) and DATA_WIDTH.
  - OPC_* and FUNCT_* encodings.
  - A packed decoded-bundle struct {alu_op, alu_a, alu_b, trap_en, illegal}.
- Sub-module mips_alu_decode: pure combinational inst/rs/rt to bundle. The top level holds the two-slot skid buffer and handshake logic.

## Test plan
- add, inst=0x00851020, rs=7, rt=9: next cycle alu_op=0x0004, A=7, B=9, trap_en=1, illegal=0.
- addiu, inst=0x2485FFFF, rs=5: alu_op=0x0004, B=0xFFFFFFFF, trap_en=0. andi, inst=0x3085FFFF: alu_op=0x0001, B=0x0000FFFF.
- sll, inst=0x000510C0, rt=0x80000001: alu_op=0x0100, A=3, B=0x80000001. lui, inst=0x3C051234: alu_op=0x0800, B=0x00001234.
- Backpressure: hold out_ready=0, offer 3 back-to-back bundles.
  - Exactly 2 are accepted, then in_ready=0.
  - On releasing out_ready, all 3 emerge in order, no duplicates.
- Illegal: inst=0xFC000000, then funct 0x3F under opcode 0: illegal=1, alu_op=0, handshake still completes.
- Reset mid-operation: both slots full, pull rst_n low between edges.
  - out_valid=0 immediately.
  - After release, in_ready=1 and no stale bundle appears.
